argmax_stream: RTL and testbench

- Streaming, parametrised argmax classifier for the output stage of the fully-connected digit-recognition network.
- Accepts class scores in signed fixed point, LANES scores per beat, over a valid/ready handshake.
- Tracks the running maximum across NUM_CLASSES scores and emits the winning class index and its score as one result per image on a second valid/ready handshake.
- Replaces single-cycle, fixed-10-input max selection with a backpressure-aware, width- and class-count-generic block.

---
 rtl/argmax_pkg.sv | 17 +
 rtl/argmax_lane_reduce.sv | 49 ++++
 rtl/argmax_stream.sv | 147 ++++++++++++++
 tb/tb_argmax_stream.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// Shared types and helpers for the streaming argmax classifier.
// Holds the FSM state encoding, the default score type and the score-width helper.
// No logic; imported by argmax_lane_reduce and argmax_stream.
package argmax_pkg;

    localparam int DEFAULT_CLASSES = 10;

    // Score at the default Q4.12 width
    typedef logic signed [15:0] score_t;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} argmax_state_t;

    function automatic int score_w(input int bits_int, input int bits_frc);
        return bits_int + bits_frc;
    endfunction

endpackage

// File: rtl/argmax_lane_reduce.sv
// Purpose: combinational signed max over the LANES scores of one beat, lowest lane wins ties.
// Ports: scores (packed, lane 0 in the LSBs) -> best, best_lane, and second (runner-up) when
//        ARGMAX_MARGIN_EN is defined. Latency 0; no handshake, purely combinational.
module argmax_lane_reduce
    import argmax_pkg::*;
#(
    parameter int BITS_INT = 4,
    parameter int BITS_FRC = 12,
    parameter int LANES    = 2,
    localparam int W       = score_w(BITS_INT, BITS_FRC),
    localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES*W-1:0]  scores,
    output logic signed [W-1:0] best,
    output logic [LW-1:0]       best_lane
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic signed [W-1:0] second
`endif
);

    always_comb begin : reduce
        logic signed [W-1:0] v;
        v         = '0;
        best      = $signed(scores[W-1:0]);
        best_lane = '0;
`ifdef ARGMAX_MARGIN_EN
        // Most-negative value is a safe "no runner-up yet" seed: any real score is >= it.
        second    = {1'b1, {(W-1){1'b0}}};
`endif
        // Strict '>' keeps the earlier lane on ties; an equal value drops to runner-up.
        for (int k = 1; k < LANES; k++) begin
            v = $signed(scores[k*W +: W]);
            if (v > best) begin
`ifdef ARGMAX_MARGIN_EN
                second = best;
`endif
                best      = v;
                best_lane = LW'(k);
            end
`ifdef ARGMAX_MARGIN_EN
            else if (v > second) begin
                second = v;
            end
`endif
        end
    end

endmodule

// File: rtl/argmax_stream.sv
// Purpose: streaming argmax over NUM_CLASSES signed scores, LANES per beat; one result per image.
// Latency: result valid the cycle after the last input beat; one idle cycle between images.
// Backpressure: in_ready drops while a result is held; outputs stay stable until out_ready.
// Ports: clk, reset (sync, active-high), in_valid/in_ready/in_scores, out_valid/out_ready,
//        out_index, out_score; out_margin/out_low_conf only when ARGMAX_MARGIN_EN is defined.
module argmax_stream
    import argmax_pkg::*;
#(
    parameter int BITS_INT    = 4,
    parameter int BITS_FRC    = 12,
    parameter int NUM_CLASSES = DEFAULT_CLASSES,
    parameter int LANES       = 2,
`ifdef ARGMAX_MARGIN_EN
    parameter int unsigned MARGIN_THR = 32'h0100,
`endif
    localparam int W          = score_w(BITS_INT, BITS_FRC),
    localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_scores,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_index,
    output logic [W-1:0]       out_score
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [W:0]         out_margin,
    output logic               out_low_conf
`endif
);

    localparam int BEATS = NUM_CLASSES / LANES;
    localparam int CW    = $clog2(BEATS) + 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    argmax_state_t       state;
    logic [CW-1:0]       cnt;
    logic signed [W-1:0] rmax, b_best, nmax;
    logic [IDX_W-1:0]    ridx, b_idx, nidx;
    logic [LW-1:0]       b_lane;
    logic                xfer_in, first_beat, last_beat;
`ifdef ARGMAX_MARGIN_EN
    logic signed [W-1:0] rsec, b_sec, nsec;
    logic [W:0]          nmargin;
    logic                nlow;
`endif

    argmax_lane_reduce #(
        .BITS_INT (BITS_INT),
        .BITS_FRC (BITS_FRC),
        .LANES    (LANES)
    ) u_reduce (
        .scores    (in_scores),
        .best      (b_best),
        .best_lane (b_lane)
`ifdef ARGMAX_MARGIN_EN
        ,
        .second    (b_sec)
`endif
    );

    assign xfer_in    = in_valid && in_ready;
    assign first_beat = (state == IDLE);
    assign last_beat  = (cnt == CW'(BEATS - 1));

    // Merge this beat's winner into the running result; the first beat of an image loads directly.
    always_comb begin
        b_idx = IDX_W'(int'(cnt) * LANES + int'(b_lane));
        if (first_beat || (b_best > rmax)) begin
            nmax = b_best;
            nidx = b_idx;
        end else begin
            nmax = rmax;
            nidx = ridx;
        end
`ifdef ARGMAX_MARGIN_EN
        // New max: old max competes with the beat's runner-up. Otherwise (ties included)
        // the beat's best competes with the old runner-up.
        if (first_beat)
            nsec = b_sec;
        else if (b_best > rmax)
            nsec = (rmax > b_sec) ? rmax : b_sec;
        else
            nsec = (b_best > rsec) ? b_best : rsec;
        // One extra bit so max - runner-up never wraps, even at full signed range.
        nmargin = {nmax[W-1], nmax} - {nsec[W-1], nsec};
        nlow    = (32'(nmargin) < MARGIN_THR);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_index <= '0;
            out_score <= '0;
            cnt       <= '0;
            rmax      <= '0;
            ridx      <= '0;
`ifdef ARGMAX_MARGIN_EN
            rsec         <= '0;
            out_margin   <= '0;
            out_low_conf <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (xfer_in) begin
                        rmax <= nmax;
                        ridx <= nidx;
`ifdef ARGMAX_MARGIN_EN
                        rsec <= nsec;
`endif
                        if (last_beat) begin
                            cnt       <= '0;
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_index <= nidx;
                            out_score <= nmax;
`ifdef ARGMAX_MARGIN_EN
                            out_margin   <= nmargin;
                            out_low_conf <= nlow;
`endif
                        end else begin
                            cnt   <= cnt + CW'(1);
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream: default instance (LANES=2, 10 classes), plus
// LANES=1/16 classes and LANES=5/10 classes instances. Margin checks when ARGMAX_MARGIN_EN is defined.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_argmax_stream;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] img [16];

    // Default instance
    logic        v1, r1, ov1, or1;
    logic [31:0] s1;
    logic [3:0]  idx1;
    logic [15:0] sc1;
    // LANES=1, 16 classes
    logic        v2, r2, ov2, or2;
    logic [15:0] s2;
    logic [3:0]  idx2;
    logic [15:0] sc2;
    // LANES=5, 10 classes
    logic        v3, r3, ov3, or3;
    logic [79:0] s3;
    logic [3:0]  idx3;
    logic [15:0] sc3;
`ifdef ARGMAX_MARGIN_EN
    logic [16:0] m1, m2, m3;
    logic        lc1, lc2, lc3;
`endif

    argmax_stream dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1), .in_scores(s1),
        .out_valid(ov1), .out_ready(or1), .out_index(idx1), .out_score(sc1)
`ifdef ARGMAX_MARGIN_EN
        , .out_margin(m1), .out_low_conf(lc1)
`endif
    );

    argmax_stream #(.NUM_CLASSES(16), .LANES(1)) dut2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_ready(r2), .in_scores(s2),
        .out_valid(ov2), .out_ready(or2), .out_index(idx2), .out_score(sc2)
`ifdef ARGMAX_MARGIN_EN
        , .out_margin(m2), .out_low_conf(lc2)
`endif
    );

    argmax_stream #(.NUM_CLASSES(10), .LANES(5)) dut3 (
        .clk(clk), .reset(reset), .in_valid(v3), .in_ready(r3), .in_scores(s3),
        .out_valid(ov3), .out_ready(or3), .out_index(idx3), .out_score(sc3)
`ifdef ARGMAX_MARGIN_EN
        , .out_margin(m3), .out_low_conf(lc3)
`endif
    );

    task automatic set_all(input logic [15:0] val);
        for (int i = 0; i < 16; i++) img[i] = val;
    endtask

    // Five beats into dut1; 'gap' idle cycles between beats. Returns one cycle after the last beat.
    task automatic feed1(input int gap);
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            if (b == 4 && gap == 0) begin
                n_total++;
                if (ov1 !== 1'b0) $display("FAIL early_valid got %b want 0", ov1); else n_pass++;
            end
            v1 = 1'b1;
            s1 = {img[2*b+1], img[2*b]};
            if (b < 4) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    v1 = 1'b0;
                end
            end
        end
        @(negedge clk);
        v1 = 1'b0;
    endtask

    task automatic feed2();
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            v2 = 1'b1;
            s2 = img[b];
        end
        @(negedge clk);
        v2 = 1'b0;
    endtask

    task automatic feed3();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            v3 = 1'b1;
            for (int k = 0; k < 5; k++) s3[k*16 +: 16] = img[b*5+k];
        end
        @(negedge clk);
        v3 = 1'b0;
    endtask

    // Pulse out_ready on every instance (ignored by those not holding a result).
    task automatic drain();
        or1 = 1'b1; or2 = 1'b1; or3 = 1'b1;
        @(negedge clk);
        or1 = 1'b0; or2 = 1'b0; or3 = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (r1 !== 1'b1)   $display("FAIL rst_in_ready got %b want 1", r1); else n_pass++;
        n_total++; if (ov1 !== 1'b0)  $display("FAIL rst_out_valid got %b want 0", ov1); else n_pass++;
        n_total++; if (idx1 !== 4'd0) $display("FAIL rst_index got %0d want 0", idx1); else n_pass++;
        n_total++; if (sc1 !== 16'h0) $display("FAIL rst_score got %h want 0000", sc1); else n_pass++;
        n_total++; if (ov2 !== 1'b0 || ov3 !== 1'b0) $display("FAIL rst_valid_other got %b%b want 00", ov2, ov3); else n_pass++;
`ifdef ARGMAX_MARGIN_EN
        n_total++; if (m1 !== 17'h0 || lc1 !== 1'b0) $display("FAIL rst_margin got %h/%b want 0/0", m1, lc1); else n_pass++;
`endif
        reset = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 10; i++) img[i] = 16'((i + 1) * 256);
        feed1(0);
        n_total++; if (ov1 !== 1'b1)     $display("FAIL basic_valid got %b want 1", ov1); else n_pass++;
        n_total++; if (idx1 !== 4'd9)    $display("FAIL basic_index got %0d want 9", idx1); else n_pass++;
        n_total++; if (sc1 !== 16'h0A00) $display("FAIL basic_score got %h want 0A00", sc1); else n_pass++;
        n_total++; if (r1 !== 1'b0)      $display("FAIL basic_hold_ready got %b want 0", r1); else n_pass++;
        drain();
        n_total++; if (ov1 !== 1'b0)     $display("FAIL basic_drain got %b want 0", ov1); else n_pass++;
    endtask

    task automatic test_ties();
        set_all(16'h0100); img[3] = 16'h0500; img[7] = 16'h0500;
        feed1(0);
        n_total++; if (idx1 !== 4'd3) $display("FAIL tie_beats got %0d want 3", idx1); else n_pass++;
        drain();
        // Same-beat tie, with idle cycles between beats
        set_all(16'h0100); img[4] = 16'h0600; img[5] = 16'h0600; img[9] = 16'h05FF;
        feed1(2);
        n_total++; if (idx1 !== 4'd4 || sc1 !== 16'h0600) $display("FAIL tie_lanes got %0d/%h want 4/0600", idx1, sc1); else n_pass++;
        drain();
    endtask

    task automatic test_negative();
        set_all(16'h8000);
        feed1(0);
        n_total++; if (idx1 !== 4'd0 || sc1 !== 16'h8000) $display("FAIL neg_all got %0d/%h want 0/8000", idx1, sc1); else n_pass++;
        drain();
        img[6] = 16'hFFFF;
        feed1(0);
        n_total++; if (idx1 !== 4'd6 || sc1 !== 16'hFFFF) $display("FAIL neg_ffff got %0d/%h want 6/FFFF", idx1, sc1); else n_pass++;
        drain();
        set_all(16'h8000); img[2] = 16'h0001; img[5] = 16'hF000;
        feed1(0);
        n_total++; if (idx1 !== 4'd2 || sc1 !== 16'h0001) $display("FAIL neg_signed got %0d/%h want 2/0001", idx1, sc1); else n_pass++;
        drain();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        set_all(16'h0100); img[0] = 16'h0700;
        feed1(0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            v1 = 1'b1; s1 = 32'h7FFF7FFF;
            if (r1 !== 1'b0 || ov1 !== 1'b1 || idx1 !== 4'd0 || sc1 !== 16'h0700) bad++;
        end
        v1 = 1'b0;
        n_total++; if (bad !== 0) $display("FAIL bp_stable got %0d bad cycles want 0", bad); else n_pass++;
        or1 = 1'b1;
        @(negedge clk);
        n_total++; if (ov1 !== 1'b0 || r1 !== 1'b1) $display("FAIL bp_release got v=%b r=%b want v=0 r=1", ov1, r1); else n_pass++;
        @(negedge clk);
        or1 = 1'b0;
        set_all(16'h0200); img[8] = 16'h0750;
        feed1(0);
        n_total++; if (idx1 !== 4'd8 || sc1 !== 16'h0750) $display("FAIL bp_second got %0d/%h want 8/0750", idx1, sc1); else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid();
        set_all(16'h0100); img[4] = 16'h7000;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            v1 = 1'b1; s1 = {img[2*b+1], img[2*b]};
        end
        @(negedge clk);
        v1 = 1'b0;
        pulse_reset();
        n_total++; if (ov1 !== 1'b0 || r1 !== 1'b1) $display("FAIL rmid_state got v=%b r=%b want v=0 r=1", ov1, r1); else n_pass++;
        set_all(16'h0100); img[2] = 16'h0300;
        feed1(0);
        n_total++; if (idx1 !== 4'd2 || sc1 !== 16'h0300) $display("FAIL rmid_fresh got %0d/%h want 2/0300", idx1, sc1); else n_pass++;
        // Reset while a result is held
        pulse_reset();
        n_total++; if (ov1 !== 1'b0 || idx1 !== 4'd0 || sc1 !== 16'h0) $display("FAIL rhold got v=%b %0d/%h want 0 0/0000", ov1, idx1, sc1); else n_pass++;
    endtask

    task automatic test_lanes1();
        set_all(16'h0100); img[1] = 16'h7000;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            v2 = 1'b1; s2 = img[b];
        end
        @(negedge clk);
        v2 = 1'b0;
        pulse_reset();
        for (int i = 0; i < 16; i++) img[i] = 16'(i * 16);
        img[2] = 16'h0300; img[14] = 16'h0300;
        feed2();
        n_total++; if (ov2 !== 1'b1) $display("FAIL l1_valid got %b want 1", ov2); else n_pass++;
        n_total++; if (idx2 !== 4'd2 || sc2 !== 16'h0300) $display("FAIL l1_fresh got %0d/%h want 2/0300", idx2, sc2); else n_pass++;
        drain();
        img[11] = 16'h0900; img[13] = 16'h0900;
        feed2();
        n_total++; if (idx2 !== 4'd11 || sc2 !== 16'h0900) $display("FAIL l1_tie got %0d/%h want 11/0900", idx2, sc2); else n_pass++;
        drain();
    endtask

    task automatic test_lanes5();
        set_all(16'h0100); img[0] = 16'h7000;
        @(negedge clk);
        v3 = 1'b1;
        for (int k = 0; k < 5; k++) s3[k*16 +: 16] = img[k];
        @(negedge clk);
        v3 = 1'b0;
        pulse_reset();
        set_all(16'h0100); img[2] = 16'h0300; img[7] = 16'h0300; img[9] = 16'h0200;
        feed3();
        n_total++; if (ov3 !== 1'b1 || idx3 !== 4'd2) $display("FAIL l5_fresh got v=%b %0d want 1 2", ov3, idx3); else n_pass++;
        drain();
        set_all(16'h0100); img[8] = 16'h0400;
        feed3();
        n_total++; if (idx3 !== 4'd8 || sc3 !== 16'h0400) $display("FAIL l5_beat1 got %0d/%h want 8/0400", idx3, sc3); else n_pass++;
        drain();
        set_all(16'h0100); img[1] = 16'h0400; img[3] = 16'h0400;
        feed3();
        n_total++; if (idx3 !== 4'd1) $display("FAIL l5_tie got %0d want 1", idx3); else n_pass++;
        drain();
    endtask

`ifdef ARGMAX_MARGIN_EN
    task automatic test_margin();
        set_all(16'h0100); img[5] = 16'h0300; img[4] = 16'h0280;
        feed1(0);
        n_total++; if (m1 !== 17'h00080 || lc1 !== 1'b1) $display("FAIL mg_low got %h/%b want 00080/1", m1, lc1); else n_pass++;
        drain();
        set_all(16'h0100); img[1] = 16'h0400; img[8] = 16'h0200;
        feed1(0);
        n_total++; if (m1 !== 17'h00200 || lc1 !== 1'b0) $display("FAIL mg_high got %h/%b want 00200/0", m1, lc1); else n_pass++;
        drain();
        set_all(16'h0100); img[3] = 16'h0500; img[7] = 16'h0500;
        feed1(0);
        n_total++; if (m1 !== 17'h0 || lc1 !== 1'b1) $display("FAIL mg_tie got %h/%b want 00000/1", m1, lc1); else n_pass++;
        drain();
        set_all(16'h8000); img[0] = 16'h7FFF;
        feed1(0);
        n_total++; if (m1 !== 17'h0FFFF || lc1 !== 1'b0) $display("FAIL mg_range got %h/%b want 0FFFF/0", m1, lc1); else n_pass++;
        drain();
    endtask
`endif

    initial begin
        reset = 1'b1;
        v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        or1 = 1'b0; or2 = 1'b0; or3 = 1'b0;
        s1 = '0; s2 = '0; s3 = '0;
        set_all(16'h0);
        test_reset();
        test_basic();
        test_ties();
        test_negative();
        test_backpressure();
        test_reset_mid();
        test_lanes1();
        test_lanes5();
`ifdef ARGMAX_MARGIN_EN
        test_margin();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
